// File: rtl/fp_maxmin_reduce.sv
// Streaming floating-point max/min reduction: returns the extreme element, its
// index and the element count of a vector, with sticky NaN and count-saturation flags.
module fp_maxmin_reduce #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 16,
    localparam int DW    = 1 + EXP_W + MANT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DW-1:0]    i_data,
    input  logic             i_last,
    input  logic             i_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DW-1:0]    o_data,
    output logic [CNT_W-1:0] o_index,
    output logic [CNT_W-1:0] o_count,
    output logic             o_nan_err,
    output logic             o_cnt_sat
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [DW-1:0]    best_q, best_d;
    logic [CNT_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nan_q, nan_d;
    logic             sat_q, sat_d;
    logic             best_ok_q, best_ok_d;

    function automatic logic is_nan(input logic [DW-1:0] x);
        return (&x[DW-2:MANT_W]) && (|x[MANT_W-1:0]);
    endfunction

    // Monotonic unsigned key: ordering of keys matches numeric ordering of the floats.
    function automatic logic [DW-1:0] fp_key(input logic [DW-1:0] x);
        return x[DW-1] ? ~x : {1'b1, x[DW-2:0]};
    endfunction

    logic in_xfer;
    logic in_nan;
    logic better;

    assign o_ready = (state_q != DONE);
    assign in_xfer = i_valid & o_ready;
    assign in_nan  = is_nan(i_data);
    assign better  = op_q ? (fp_key(i_data) < fp_key(best_q))
                          : (fp_key(i_data) > fp_key(best_q));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        cnt_d      = cnt_q;
        nan_d      = nan_q;
        sat_d      = sat_q;
        best_ok_d  = best_ok_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    op_d       = i_op;
                    best_d     = i_data;
                    best_idx_d = '0;
                    cnt_d      = CNT_W'(1);
                    nan_d      = in_nan;
                    sat_d      = 1'b0;
                    best_ok_d  = ~in_nan;
                    state_d    = i_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // A NaN held as best (leading NaNs) yields to the first real value.
                    if (!in_nan && (!best_ok_q || better)) begin
                        best_d     = i_data;
                        best_idx_d = cnt_q;
                        best_ok_d  = 1'b1;
                    end
                    nan_d = nan_q | in_nan;
                    if (i_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
            cnt_q      <= '0;
            nan_q      <= 1'b0;
            sat_q      <= 1'b0;
            best_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            cnt_q      <= cnt_d;
            nan_q      <= nan_d;
            sat_q      <= sat_d;
            best_ok_q  <= best_ok_d;
        end
    end

    assign o_valid   = (state_q == DONE);
    assign o_data    = nan_q ? '1 : best_q;
    assign o_index   = best_idx_q;
    assign o_count   = cnt_q;
    assign o_nan_err = nan_q;
    assign o_cnt_sat = sat_q;

endmodule

// File: tb/tb_fp_maxmin_reduce.sv
// Directed bench for fp_maxmin_reduce: FP32 default instance plus a CNT_W=2
// instance sharing the same input stream for the count-saturation scenario.
module tb_fp_maxmin_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_last, i_op, i_ready;
    logic [31:0] i_data;

    logic        o_ready, o_valid, o_nan_err, o_cnt_sat;
    logic [31:0] o_data;
    logic [15:0] o_index, o_count;

    logic        s_ready, s_valid, s_nan_err, s_cnt_sat;
    logic [31:0] s_data;
    logic [1:0]  s_index, s_count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fp_maxmin_reduce dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .i_op(i_op), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_index(o_index), .o_count(o_count),
        .o_nan_err(o_nan_err), .o_cnt_sat(o_cnt_sat)
    );

    fp_maxmin_reduce #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(s_ready),
        .i_data(i_data), .i_last(i_last), .i_op(i_op), .o_valid(s_valid),
        .i_ready(i_ready), .o_data(s_data), .o_index(s_index), .o_count(s_count),
        .o_nan_err(s_nan_err), .o_cnt_sat(s_cnt_sat)
    );

    // One element transfer; returns #1 after the accepting edge.
    task automatic drive(input logic [31:0] d, input logic last, input logic op);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        i_op    = op;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        $display("  send data=%08h last=%0b op=%0b", d, last, op);
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        while (!o_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        compared++;
        if (o_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s timeout: o_valid=%b required 1", name, o_valid);
        end
        $display("  result %s: data=%08h idx=%0d cnt=%0d nan=%0b sat=%0b",
                 name, o_data, o_index, o_count, o_nan_err, o_cnt_sat);
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compared++;
        if ({o_valid, o_ready, o_nan_err, o_cnt_sat} !== 4'b0100) begin
            mismatched++;
            $display("FAIL reset_flags: valid/ready/nan/sat=%b required 0100",
                     {o_valid, o_ready, o_nan_err, o_cnt_sat});
        end
        compared++;
        if (o_data !== 32'h0 || o_index !== 16'd0 || o_count !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_values: data=%08h idx=%0d cnt=%0d required 0/0/0",
                     o_data, o_index, o_count);
        end
        $display("  reset done");
    endtask

    task automatic test_max_basic();
        drive(32'h3F800000, 1'b0, 1'b0);
        drive(32'h40400000, 1'b0, 1'b0);
        drive(32'hC0000000, 1'b0, 1'b0);
        drive(32'h40400000, 1'b1, 1'b0);
        compared++;
        if (o_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL max_latency: o_valid=%b required 1", o_valid);
        end
        wait_result("max_basic");
        compared++;
        if (o_data !== 32'h40400000 || o_index !== 16'd1 || o_count !== 16'd4 || o_nan_err !== 1'b0) begin
            mismatched++;
            $display("FAIL max_basic: data=%08h idx=%0d cnt=%0d nan=%b required 40400000/1/4/0",
                     o_data, o_index, o_count, o_nan_err);
        end
        release_result();
        compared++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL max_release: valid=%b ready=%b required 0/1", o_valid, o_ready);
        end
    endtask

    task automatic test_signed_zero();
        drive(32'h00000000, 1'b0, 1'b1);
        drive(32'h80000000, 1'b0, 1'b1);
        drive(32'h00000001, 1'b1, 1'b1);
        wait_result("min_zero");
        compared++;
        if (o_data !== 32'h80000000 || o_index !== 16'd1 || o_count !== 16'd3) begin
            mismatched++;
            $display("FAIL min_zero: data=%08h idx=%0d cnt=%0d required 80000000/1/3",
                     o_data, o_index, o_count);
        end
        release_result();
        drive(32'h00000000, 1'b0, 1'b0);
        drive(32'h80000000, 1'b0, 1'b0);
        drive(32'h00000001, 1'b1, 1'b0);
        wait_result("max_zero");
        compared++;
        if (o_data !== 32'h00000001 || o_index !== 16'd2) begin
            mismatched++;
            $display("FAIL max_zero: data=%08h idx=%0d required 00000001/2", o_data, o_index);
        end
        release_result();
    endtask

    task automatic test_nan();
        drive(32'hFF800000, 1'b0, 1'b0);
        drive(32'h7F800000, 1'b0, 1'b0);
        drive(32'h7FC00000, 1'b0, 1'b0);
        drive(32'h3F800000, 1'b1, 1'b0);
        wait_result("nan_mix");
        compared++;
        if (o_data !== 32'hFFFFFFFF || o_nan_err !== 1'b1 || o_index !== 16'd1 || o_count !== 16'd4) begin
            mismatched++;
            $display("FAIL nan_mix: data=%08h nan=%b idx=%0d cnt=%0d required FFFFFFFF/1/1/4",
                     o_data, o_nan_err, o_index, o_count);
        end
        release_result();
        drive(32'h7FC00000, 1'b0, 1'b0);
        drive(32'hFFC00001, 1'b1, 1'b0);
        wait_result("all_nan");
        compared++;
        if (o_data !== 32'hFFFFFFFF || o_nan_err !== 1'b1 || o_index !== 16'd0 || o_count !== 16'd2) begin
            mismatched++;
            $display("FAIL all_nan: data=%08h nan=%b idx=%0d cnt=%0d required FFFFFFFF/1/0/2",
                     o_data, o_nan_err, o_index, o_count);
        end
        release_result();
        drive(32'h7FC00000, 1'b0, 1'b0);
        drive(32'hC0000000, 1'b0, 1'b0);
        drive(32'h3F800000, 1'b1, 1'b0);
        wait_result("lead_nan");
        compared++;
        if (o_nan_err !== 1'b1 || o_index !== 16'd2 || o_count !== 16'd3) begin
            mismatched++;
            $display("FAIL lead_nan: nan=%b idx=%0d cnt=%0d required 1/2/3",
                     o_nan_err, o_index, o_count);
        end
        release_result();
    endtask

    task automatic test_op_change();
        drive(32'h3F800000, 1'b0, 1'b0);
        i_last = 1'b1;
        @(posedge clk);
        #1;
        i_last = 1'b0;
        compared++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL last_no_valid: valid=%b ready=%b required 0/1", o_valid, o_ready);
        end
        drive(32'h40000000, 1'b0, 1'b1);
        drive(32'h3F000000, 1'b1, 1'b1);
        wait_result("op_change");
        compared++;
        if (o_data !== 32'h40000000 || o_index !== 16'd1 || o_count !== 16'd3) begin
            mismatched++;
            $display("FAIL op_change: data=%08h idx=%0d cnt=%0d required 40000000/1/3",
                     o_data, o_index, o_count);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        drive(32'h40000000, 1'b0, 1'b1);
        drive(32'h3F800000, 1'b1, 1'b1);
        wait_result("backpressure");
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'h3F800000 ||
                o_index !== 16'd1 || o_count !== 16'd2) begin
                mismatched++;
                $display("FAIL hold_%0d: ready=%b valid=%b data=%08h idx=%0d cnt=%0d required 0/1/3F800000/1/2",
                         i, o_ready, o_valid, o_data, o_index, o_count);
            end
            @(posedge clk);
            #1;
        end
        release_result();
        compared++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_release: ready=%b valid=%b required 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_reset_abort();
        drive(32'h7FC00000, 1'b0, 1'b0);
        drive(32'h7F000000, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        compared++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_count !== 16'd0) begin
            mismatched++;
            $display("FAIL abort_reset: ready=%b valid=%b cnt=%0d required 1/0/0",
                     o_ready, o_valid, o_count);
        end
        drive(32'hBF800000, 1'b1, 1'b1);
        wait_result("abort_single");
        compared++;
        if (o_data !== 32'hBF800000 || o_count !== 16'd1 || o_index !== 16'd0 || o_nan_err !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_single: data=%08h cnt=%0d idx=%0d nan=%b required BF800000/1/0/0",
                     o_data, o_count, o_index, o_nan_err);
        end
        release_result();
    endtask

    task automatic test_saturation();
        drive(32'h3F800000, 1'b0, 1'b0);
        drive(32'h40000000, 1'b0, 1'b0);
        drive(32'h3F800000, 1'b0, 1'b0);
        drive(32'h40400000, 1'b0, 1'b0);
        drive(32'h41000000, 1'b1, 1'b0);
        wait_result("saturation");
        compared++;
        if (s_valid !== 1'b1 || s_data !== 32'h41000000 || s_index !== 2'd3 ||
            s_count !== 2'd3 || s_cnt_sat !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_small: valid=%b data=%08h idx=%0d cnt=%0d sat=%b required 1/41000000/3/3/1",
                     s_valid, s_data, s_index, s_count, s_cnt_sat);
        end
        compared++;
        if (o_data !== 32'h41000000 || o_index !== 16'd4 || o_count !== 16'd5 || o_cnt_sat !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_wide: data=%08h idx=%0d cnt=%0d sat=%b required 41000000/4/5/0",
                     o_data, o_index, o_count, o_cnt_sat);
        end
        release_result();
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_op    = 1'b0;
        i_ready = 1'b0;
        i_data  = 32'h0;
        test_reset();
        test_max_basic();
        test_signed_zero();
        test_nan();
        test_op_change();
        test_backpressure();
        test_reset_abort();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
